clkdiv_ctrl: RTL and testbench

- Configuration controller for the team's integer clock divider; several requesters share one divider and each asks for its own divide ratio.
- Round-robin arbitration picks one request, drives the divider's ratio input and masks the divided clock while the ratio changes.
- Acknowledges the requester only after the divider has settled on the new ratio.
- Sits in the clock-management domain next to the divider and runs on the divider's source clock.

---
 rtl/clkdiv_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/clkdiv_ctrl.sv | 109 ++++++++++
 tb/tb_clkdiv_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock-divider configuration controller.
package clkdiv_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } state_t;

  // Default divider ratio width and the width of the settle counter
  localparam int RATIO_W  = 8;
  localparam int SETTLE_W = RATIO_W + 2;

  // Settle window after a ratio switch: the divider needs up to one full
  // period of the old ratio plus one of the new one, plus fixed guard cycles.
  function automatic int unsigned settle_cycles(input int unsigned old_ratio,
                                                input int unsigned new_ratio,
                                                input int unsigned extra);
    return old_ratio + new_ratio + 32'd2 + extra;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request after last_grant, with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  int pos;

  // Scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = (int'(last_grant) + k) % NREQ;
      if (req[pos]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Configuration controller for a shared integer clock divider: arbitrates
// ratio requests, reprograms the divider with the divided clock gated, and
// acknowledges the requester once the divider has settled.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int          NREQ         = 4,
  parameter int          W            = RATIO_W,
  parameter int unsigned SETTLE_EXTRA = 2,
  parameter int          IW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] ratio,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      divide_out,
  output logic              gate_en,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  localparam int CNT_W = W + 2;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last_grant;
  logic [W-1:0]     new_ratio;
  logic [CNT_W-1:0] cnt;

  logic             grant_valid;
  logic [IW-1:0]    grant_idx;
  logic [W-1:0]     sel_ratio;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_ratio = ratio[int'(grant_idx) * W +: W];

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Controller FSM; every output is registered so req/ratio never reach an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= IW'(NREQ - 1);
      new_ratio  <= '0;
      cnt        <= '0;
      ack        <= '0;
      divide_out <= '0;
      gate_en    <= 1'b1;
      busy       <= 1'b0;
      owner      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            idx       <= grant_idx;
            new_ratio <= sel_ratio;
            busy      <= 1'b1;
            if (sel_ratio == divide_out) begin
              // Divider already runs at the requested ratio: acknowledge directly
              state <= ACK;
              ack   <= onehot(grant_idx);
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          divide_out <= new_ratio;
          gate_en    <= 1'b0;
          cnt        <= CNT_W'(settle_cycles(32'(divide_out), 32'(new_ratio), SETTLE_EXTRA));
          state      <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            gate_en <= 1'b1;
            ack     <= onehot(idx);
            state   <= ACK;
          end
        end
        ACK: begin
          last_grant <= idx;
          owner      <= idx;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_clkdiv_ctrl;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int EXTRA = 2;
  localparam int IW    = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] ratio;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      divide_out;
  logic              gate_en;
  logic              busy;
  logic [IW-1:0]     owner;

  int n_checks = 0;
  int n_fail   = 0;

  clkdiv_ctrl #(
    .NREQ         (NREQ),
    .W            (W),
    .SETTLE_EXTRA (EXTRA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .ratio      (ratio),
    .ack        (ack),
    .divide_out (divide_out),
    .gate_en    (gate_en),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction schedule) ----------------
  int              m_div, m_owner, m_last;
  logic            m_gate, m_busy;
  logic [NREQ-1:0] m_ack;
  bit              m_active, m_eq;
  int              m_g, m_new, m_S, m_e, cyc;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_div = 0; m_gate = 1'b1; m_ack = '0; m_busy = 1'b0;
        m_owner = 0; m_last = NREQ - 1; m_active = 0; cyc = 0;
      end else begin
        cyc++;
        if (!m_active) begin
          m_g = rr_pick(req, m_last);
          if (m_g >= 0) begin
            m_active = 1;
            m_new    = int'(ratio[m_g*W +: W]);
            m_eq     = (m_new == m_div);
            m_S      = m_div + m_new + 2 + EXTRA;
            m_e      = cyc;
          end
        end
        if (m_active) begin
          int d;
          d     = cyc - m_e;
          m_ack = '0;
          if (m_eq) begin
            if (d == 0) begin
              m_busy = 1'b1; m_ack = NREQ'(1) << m_g;
            end else if (d == 1) begin
              m_busy = 1'b0; m_owner = m_g; m_last = m_g; m_active = 0;
            end
          end else begin
            if (d == 0) begin
              m_busy = 1'b1;
            end else if (d == 1) begin
              m_div = m_new; m_gate = 1'b0;
            end else if (d == 1 + m_S) begin
              m_gate = 1'b1; m_ack = NREQ'(1) << m_g;
            end else if (d == 2 + m_S) begin
              m_busy = 1'b0; m_owner = m_g; m_last = m_g; m_active = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ack", ack, m_ack);
        check("divide_out", divide_out, m_div);
        check("gate_en", gate_en, m_gate);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        check("ack_onehot", ($countones(ack) <= 1), 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic do_req(input int idx, input int r, input int drop_after,
                        output int cycles, output int glow, output logic acked);
    wait_idle();
    @(negedge clk);
    ratio[idx*W +: W] = W'(r);
    req[idx] = 1'b1;
    cycles = 0; glow = 0; acked = 1'b0;
    while (!acked && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (!gate_en) glow++;
      if (ack[idx]) acked = 1'b1;
      if (cycles == drop_after) req[idx] = 1'b0;
    end
    req[idx] = 1'b0;
  endtask

  function automatic int ack_index(input logic [NREQ-1:0] a);
    for (int i = 0; i < NREQ; i++) if (a[i]) return i;
    return -1;
  endfunction

  int   cyc_n, glow_n, n_acks, guard;
  logic acked;
  int   order [5];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ratio = '0;
    repeat (3) @(negedge clk);
    check("rst_divide_out", divide_out, 0);
    check("rst_gate_en", gate_en, 1);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    rst_n = 1'b1;

    // Single request: ratio 4 from bypass -> S = 0+4+2+2 = 8
    do_req(0, 4, -1, cyc_n, glow_n, acked);
    check("s1_acked", acked, 1);
    check("s1_latency", cyc_n, 10);
    check("s1_gate_low", glow_n, 8);
    check("s1_divide_out", divide_out, 4);
    wait_idle();
    check("s1_owner", owner, 0);

    // Equal ratio: no reprogramming, ack on the next cycle
    do_req(2, 4, -1, cyc_n, glow_n, acked);
    check("s2_acked", acked, 1);
    check("s2_latency", cyc_n, 1);
    check("s2_gate_low", glow_n, 0);
    check("s2_divide_out", divide_out, 4);
    wait_idle();
    check("s2_owner", owner, 2);

    // Round-robin from reset with all four requesting
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ratio = {8'd5, 8'd3, 8'd5, 8'd3};
    req   = '1;
    n_acks = 0; guard = 0;
    while (n_acks < 5 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (|ack) begin
        order[n_acks] = ack_index(ack);
        n_acks++;
      end
    end
    req = '0;
    check("rr_ack_count", n_acks, 5);
    for (int i = 0; i < 5; i++) check($sformatf("rr_order_%0d", i), order[i], i % NREQ);

    // Ratio change sizing: 10 -> 7 gives S = 10+7+2+2 = 21
    do_req(0, 10, -1, cyc_n, glow_n, acked);
    check("s4_pre_divide_out", divide_out, 10);
    do_req(1, 7, -1, cyc_n, glow_n, acked);
    check("s4_acked", acked, 1);
    check("s4_gate_low", glow_n, 21);
    check("s4_divide_out", divide_out, 7);

    // Request dropped during SETTLE still completes and acks
    do_req(3, 9, 5, cyc_n, glow_n, acked);
    check("s5_acked", acked, 1);
    check("s5_gate_low", glow_n, 20);
    check("s5_divide_out", divide_out, 9);
    do_req(0, 2, -1, cyc_n, glow_n, acked);
    check("s5_next_acked", acked, 1);
    check("s5_next_divide_out", divide_out, 2);

    // Reset asserted during SETTLE
    wait_idle();
    @(negedge clk);
    ratio[1*W +: W] = 8'd50;
    req[1] = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("s6_divide_out", divide_out, 0);
    check("s6_gate_en", gate_en, 1);
    check("s6_busy", busy, 0);
    check("s6_ack", ack, 0);
    check("s6_owner", owner, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ratio = {8'd6, 8'd7, 8'd8, 8'd9};
    req   = '1;
    n_acks = 0; guard = 0;
    while (n_acks < 1 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (|ack) begin
        order[0] = ack_index(ack);
        n_acks++;
      end
    end
    req = '0;
    check("s6_first_ack_seen", n_acks, 1);
    check("s6_first_grant", order[0], 0);
    wait_idle();

    // Randomized traffic against the reference model
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0)
          ratio[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
      end
    end
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
